// File: rtl/trellis_mul_pkg.sv
// Shared constants and types for the TrellisBuilder multiplier arbiter.
// Defaults match the 10b x 11b, 3-stage shared multiplier.
package trellis_mul_pkg;

  localparam int NUM_REQ     = 4;
  localparam int A_WIDTH     = 10;
  localparam int B_WIDTH     = 11;
  localparam int P_WIDTH     = A_WIDTH + B_WIDTH;
  localparam int MUL_LATENCY = 3;
  localparam int ID_WIDTH    = $clog2(NUM_REQ);

  typedef logic [ID_WIDTH-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Round-robin successor of idx modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/trellis_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, only when en is high.
// Purely combinational; grant_idx falls back to ptr when nothing is granted.
module trellis_rr_arbiter
  import trellis_mul_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_any
);

  logic           found;
  logic [IDW-1:0] found_idx;

  always_comb begin
    found     = 1'b0;
    found_idx = ptr;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        found_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = en && found;
    grant_idx = grant_any ? found_idx : ptr;
    if (grant_any) grant[found_idx] = 1'b1;
  end

endmodule

// File: rtl/trellis_mul_arbiter.sv
// Shares one ce-gated pipelined multiplier among NUM_REQ requesters (stats: TRELLIS_MUL_ARB_STATS_EN).
// Latency: issue edge to rsp_valid equals MUL_LATENCY edges; one issue per cycle.
// Backpressure: rsp_valid & ~rsp_ready drops mul_ce, freezing multiplier, tags and grants.
module trellis_mul_arbiter
  import trellis_mul_pkg::*;
#(
  parameter int NUM_REQ     = trellis_mul_pkg::NUM_REQ,
  parameter int A_WIDTH     = trellis_mul_pkg::A_WIDTH,
  parameter int B_WIDTH     = trellis_mul_pkg::B_WIDTH,
  parameter int P_WIDTH     = A_WIDTH + B_WIDTH,
  parameter int MUL_LATENCY = trellis_mul_pkg::MUL_LATENCY,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout
`ifdef TRELLIS_MUL_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*16-1:0]      stat_issue_cnt,
  output logic [15:0]                stat_stall_cnt
`endif
);

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic                   stall;
  logic [MUL_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]        tag_id [MUL_LATENCY];

  assign stall  = rsp_valid && !rsp_ready;
  assign mul_ce = !stall;

  // Grants are suppressed while reset is asserted so nothing is accepted that would be lost.
  trellis_rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (mul_ce && !reset),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign mul_din0 = req_a[int'(grant_idx)*A_WIDTH +: A_WIDTH];
  assign mul_din1 = req_b[int'(grant_idx)*B_WIDTH +: B_WIDTH];

  assign rsp_valid = tag_vld[MUL_LATENCY-1];
  assign rsp_id    = tag_id[MUL_LATENCY-1];
  assign rsp_p     = mul_dout;

  // Tags advance in lockstep with the multiplier stages so the id lines up with mul_dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      tag_vld <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      if (grant_any) rr_ptr <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
      if (mul_ce) begin
        tag_vld[0] <= grant_any;
        tag_id[0]  <= grant_idx;
        for (int s = 1; s < MUL_LATENCY; s++) begin
          tag_vld[s] <= tag_vld[s-1];
          tag_id[s]  <= tag_id[s-1];
        end
      end
    end
  end

`ifdef TRELLIS_MUL_ARB_STATS_EN
  logic [15:0] issue_cnt [NUM_REQ];
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && issue_cnt[i] != 16'hFFFF) issue_cnt[i] <= issue_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_issue_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_issue_cnt[i*16 +: 16] = issue_cnt[i];
  end

  assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_trellis_mul_arbiter.sv
// Directed bench for trellis_mul_arbiter paired with a 3-stage ce-gated multiplier model.
module tb_trellis_mul_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_a;
  logic [43:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [20:0] rsp_p;
  logic        mul_ce;
  logic [9:0]  mul_din0;
  logic [10:0] mul_din1;
  logic [20:0] mul_dout;
`ifdef TRELLIS_MUL_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_issue_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Products of a=10+i, b=100+i for requester i.
  int exp_p [4] = '{1000, 1111, 1224, 1339};

  trellis_mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout)
`ifdef TRELLIS_MUL_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  logic [20:0] m0, m1, m2;
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      m0 <= 21'(mul_din0) * 21'(mul_din1);
      m1 <= m0;
      m2 <= m1;
    end
  end
  assign mul_dout = m2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*10 +: 10] = 10'(a);
    req_b[i*11 +: 11] = 11'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] e;
    reset = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
`ifdef TRELLIS_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    reset = 1'b0;
    req_valid = 4'b0000;

    // Single request
    set_op(2, 1023, 2047);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_din0", mul_din0, 1023);
    chk("t1_din1", mul_din1, 2047);
    step();
    req_valid = 4'b0000;
    #1;
    chk("t1_ready_drop", req_ready, 4'b0000);
    chk("t1_vld_e1", rsp_valid, 1'b0);
    step();
    #1;
    chk("t1_vld_e2", rsp_valid, 1'b0);
    step();
    #1;
    chk("t1_vld_e3", rsp_valid, 1'b1);
    chk("t1_p", rsp_p, 2094081);
    chk("t1_id", rsp_id, 2);
    step();
    #1;
    chk("t1_vld_after", rsp_valid, 1'b0);

    // Fairness with all requesters active
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 10 + i, 100 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) req_valid = 4'b0000;
      #1;
      e = 4'b0001 << (k % 4);
      if (k < 8) chk("t2_grant", req_ready, e);
      else       chk("t2_grant_idle", req_ready, 4'b0000);
      if (k >= 3 && k <= 10) begin
        chk("t2_vld", rsp_valid, 1'b1);
        chk("t2_id", rsp_id, (k - 3) % 4);
        chk("t2_p", rsp_p, exp_p[(k - 3) % 4]);
      end else begin
        chk("t2_vld_idle", rsp_valid, 1'b0);
      end
      step();
    end

    // Backpressure: three issued, requester 3 waits through the stall
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = 4'b0001 << k;
      chk("t3_grant", req_ready, e);
      step();
    end
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("t3_ce", mul_ce, 1'b0);
      chk("t3_ready", req_ready, 4'b0000);
      chk("t3_vld", rsp_valid, 1'b1);
      chk("t3_id", rsp_id, 0);
      chk("t3_p", rsp_p, 1000);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_rel_ce", mul_ce, 1'b1);
    chk("t3_rel_ready", req_ready, 4'b1000);
    chk("t3_rel_p", rsp_p, 1000);
    step();
    req_valid = 4'b0000;
    for (int j = 1; j < 4; j++) begin
      #1;
      chk("t3_drain_vld", rsp_valid, 1'b1);
      chk("t3_drain_id", rsp_id, j);
      chk("t3_drain_p", rsp_p, exp_p[j]);
      step();
    end
    #1;
    chk("t3_empty", rsp_valid, 1'b0);

    // Pointer skip and wrap
    set_op(0, 3, 4);
    req_valid = 4'b0001;
    #1;
    chk("t4_first", req_ready, 4'b0001);
    step();
    set_op(0, 0, 7);
    #1;
    chk("t4_skip", req_ready, 4'b0001);
    step();
    set_op(1, 6, 5);
    req_valid = 4'b0011;
    #1;
    chk("t4_ptr", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    #1;
    chk("t4_p0", rsp_p, 12);
    chk("t4_id0", rsp_id, 0);
    step();
    #1;
    chk("t4_vld1", rsp_valid, 1'b1);
    chk("t4_p1", rsp_p, 0);
    chk("t4_id1", rsp_id, 0);
    step();
    #1;
    chk("t4_p2", rsp_p, 30);
    chk("t4_id2", rsp_id, 1);
    step();
    #1;
    chk("t4_empty", rsp_valid, 1'b0);

    // Reset while products are in flight
    req_valid = 4'b0011;
    #1;
    chk("t5_grant0", req_ready, 4'b0001);
    step();
    #1;
    chk("t5_grant1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    step();
    #1;
    chk("t5_pre_vld", rsp_valid, 1'b1);
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t5_rst_vld", rsp_valid, 1'b0);
    chk("t5_rst_ready", req_ready, 4'b0000);
    chk("t5_rst_id", rsp_id, 0);
    step();
    reset = 1'b0;
    req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_post_vld", rsp_valid, 1'b0);
      step();
    end

`ifdef TRELLIS_MUL_ARB_STATS_EN
    do_reset();
    chk("t6_issue_rst", stat_issue_cnt[16 +: 16], 0);
    chk("t6_stall_rst", stat_stall_cnt, 0);
    set_op(1, 1, 1);
    req_valid = 4'b0010;
    repeat (10) begin
      #1;
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    #1;
    chk("t6_issue", stat_issue_cnt[16 +: 16], 10);
    chk("t6_issue_other", stat_issue_cnt[0 +: 16], 0);
    chk("t6_stall", stat_stall_cnt, 3);
    repeat (4) step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    chk("t6_clr_issue", stat_issue_cnt[16 +: 16], 0);
    chk("t6_clr_stall", stat_stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
